// File: rtl/strassen_seq2x2.sv
// strassen_seq2x2: sequential 2x2 Strassen multiply through one shared pipelined multiplier.
// Seven (full) or four (partial: C01/C10 only) products are accumulated, then saturated.
module strassen_seq2x2 #(
  parameter int DATAWIDTH    = 32,
  parameter int OUTWIDTH     = 2*DATAWIDTH,
  parameter int MULT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DATAWIDTH-1:0]  A,
  input  logic [4*DATAWIDTH-1:0]  B,
  input  logic                    sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*OUTWIDTH-1:0]   C_out,
  output logic                    ovf,
  output logic                    busy
);
  localparam int DW = DATAWIDTH;
  localparam int PW = 2*DW+2;
  localparam int AW = 2*DW+4;
  localparam int OW = OUTWIDTH;
  localparam int L  = MULT_LATENCY;
  localparam logic signed [AW-1:0] HI = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] LO = ~HI;
  // bit (7*element + product index) selects which products add into / subtract from each C element
  localparam logic [27:0] PLUS  = {7'b0100101, 7'b0001010, 7'b0010100, 7'b1001001};
  localparam logic [27:0] MINUS = {7'b0000010, 7'b0000000, 7'b0000000, 7'b0010000};
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [4*DW-1:0] a_r, b_r;
  logic sel_r, accept, issue, last_issue, fin;
  logic [2:0] cnt, idx;
  logic signed [DW:0] a00, a01, a10, a11, b00, b01, b10, b11, x, y;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] pp [L];
  logic [2:0] pix [L];
  logic [L-1:0] pv, pl;
  logic signed [AW-1:0] pe;
  logic signed [AW-1:0] acc [4];
  logic signed [AW-1:0] acc_n [4];
  logic [OW-1:0] sat [4];
  logic [3:0] ov, hf, lf, z;
  function automatic logic signed [DW:0] ext(input logic [4*DW-1:0] m, input int i);
    return {m[i*DW+DW-1], m[i*DW +: DW]};
  endfunction
  assign a00 = ext(a_r, 0);
  assign a01 = ext(a_r, 1);
  assign a10 = ext(a_r, 2);
  assign a11 = ext(a_r, 3);
  assign b00 = ext(b_r, 0);
  assign b01 = ext(b_r, 1);
  assign b10 = ext(b_r, 2);
  assign b11 = ext(b_r, 3);
  assign idx        = cnt + {2'b0, sel_r};
  assign last_issue = cnt == (sel_r ? 3'd3 : 3'd6);
  assign fin        = pv[L-1] & pl[L-1];
  assign prod       = PW'(x) * PW'(y);
  assign pe         = AW'(pp[L-1]);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid   ? ISSUE : IDLE;
      ISSUE:   state_n = last_issue ? DRAIN : ISSUE;
      DRAIN:   state_n = fin        ? DONE  : DRAIN;
      default: state_n = out_ready  ? IDLE  : DONE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE && !rst;
    busy      = state != IDLE;
    out_valid = state == DONE;
    issue     = state == ISSUE;
    accept    = in_valid && in_ready;
  end
  always_comb begin
    x = '0;
    y = '0;
    case (idx)
      3'd0:    begin x = a00 + a11; y = b00 + b11; end
      3'd1:    begin x = a10 + a11; y = b00;       end
      3'd2:    begin x = a00;       y = b01 - b11; end
      3'd3:    begin x = a11;       y = b10 - b00; end
      3'd4:    begin x = a00 + a01; y = b11;       end
      3'd5:    begin x = a10 - a00; y = b00 + b01; end
      default: begin x = a01 - a11; y = b10 + b11; end
    endcase
  end
  // next-accumulator values also feed saturation so the result registers on the last product's edge
  always_comb begin
    hf = '0;
    lf = '0;
    z  = '0;
    ov = '0;
    for (int e = 0; e < 4; e++) begin
      acc_n[e] = acc[e] + ((pv[L-1] && PLUS[e*7+int'(pix[L-1])]) ? pe : '0)
                        - ((pv[L-1] && MINUS[e*7+int'(pix[L-1])]) ? pe : '0);
      hf[e]  = acc_n[e] > HI;
      lf[e]  = acc_n[e] < LO;
      z[e]   = sel_r && (e == 0 || e == 3);
      ov[e]  = !z[e] && (hf[e] || lf[e]);
      sat[e] = z[e] ? '0 : hf[e] ? HI[OW-1:0] : lf[e] ? LO[OW-1:0] : acc_n[e][OW-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sel_r <= 1'b0;
      cnt   <= '0;
      pv    <= '0;
      pl    <= '0;
      C_out <= '0;
      ovf   <= 1'b0;
      for (int e = 0; e < 4; e++) acc[e] <= '0;
      for (int i = 0; i < L; i++) begin
        pp[i]  <= '0;
        pix[i] <= '0;
      end
    end else begin
      if (accept) begin
        a_r   <= A;
        b_r   <= B;
        sel_r <= sel;
        cnt   <= '0;
        for (int e = 0; e < 4; e++) acc[e] <= '0;
      end else begin
        if (issue) cnt <= cnt + 3'd1;
        if (pv[L-1]) for (int e = 0; e < 4; e++) acc[e] <= acc_n[e];
      end
      pv[0]  <= issue;
      pl[0]  <= issue && last_issue;
      pp[0]  <= prod;
      pix[0] <= idx;
      for (int i = 1; i < L; i++) begin
        pv[i]  <= pv[i-1];
        pl[i]  <= pl[i-1];
        pp[i]  <= pp[i-1];
        pix[i] <= pix[i-1];
      end
      if (state == DRAIN && fin) begin
        C_out <= {sat[3], sat[2], sat[1], sat[0]};
        ovf   <= |ov;
      end
    end
  end
endmodule

// File: tb/tb_strassen_seq2x2.sv
// tb_strassen_seq2x2: two configurations driven in lockstep (32/64-bit lat 1, 8/8-bit lat 3),
// checked against a plain matrix-multiply model with output clamping.
module tb_strassen_seq2x2;
  logic clk = 0, rst, in_valid, sel, out_ready;
  logic [127:0] A0, B0;
  logic [31:0]  A1, B1;
  logic [255:0] C0;
  logic [31:0]  C1;
  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1, busy0, busy1;
  int n_tot = 0, n_bad = 0;
  int aa0[4], bb0[4], aa1[4], bb1[4];
  strassen_seq2x2 dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .A(A0), .B(B0), .sel(sel),
    .out_valid(out_valid0), .out_ready(out_ready), .C_out(C0), .ovf(ovf0), .busy(busy0)
  );
  strassen_seq2x2 #(.DATAWIDTH(8), .OUTWIDTH(8), .MULT_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(A1), .B(B1), .sel(sel),
    .out_valid(out_valid1), .out_ready(out_ready), .C_out(C1), .ovf(ovf1), .busy(busy1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [67:0] got, input logic signed [67:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic void model(input int a[4], input int b[4], input bit s, input int ow,
                                output logic signed [67:0] c[4], output bit o);
    logic signed [67:0] hi, lo, v;
    hi = (68'sd1 <<< (ow-1)) - 68'sd1;
    lo = -hi - 68'sd1;
    o = 0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        v = 68'(a[2*r]) * 68'(b[k]) + 68'(a[2*r+1]) * 68'(b[2+k]);
        if (s && r == k) c[2*r+k] = 0;
        else begin
          c[2*r+k] = v > hi ? hi : v < lo ? lo : v;
          o |= (v > hi || v < lo);
        end
      end
  endfunction
  task automatic pack();
    for (int e = 0; e < 4; e++) begin
      A0[e*32 +: 32] = aa0[e];
      B0[e*32 +: 32] = bb0[e];
      A1[e*8 +: 8]   = aa1[e][7:0];
      B1[e*8 +: 8]   = bb1[e][7:0];
    end
  endtask
  task automatic job(input bit s, input int hold);
    logic signed [67:0] e0[4], e1[4];
    logic signed [67:0] g;
    bit o0, o1, bad_ir;
    int l0, l1;
    model(aa0, bb0, s, 64, e0, o0);
    model(aa1, bb1, s, 8, e1, o1);
    @(negedge clk);
    pack();
    sel = s;
    in_valid = 1;
    chk("in_ready_idle", {in_ready0, in_ready1}, 3);
    l0 = 0;
    l1 = 0;
    bad_ir = 0;
    for (int c = 1; c <= 40 && (l0 == 0 || l1 == 0); c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      A0 = {$urandom, $urandom, $urandom, $urandom};
      if (out_valid0 && l0 == 0) l0 = c;
      if (out_valid1 && l1 == 0) l1 = c;
      if (in_ready0 || in_ready1 || !busy0 || !busy1) bad_ir = 1;
    end
    chk("lat0", l0, s ? 6 : 9);
    chk("lat1", l1, s ? 8 : 11);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'(h & 1);
      if (in_ready0 || in_ready1 || !busy0 || !busy1) bad_ir = 1;
    end
    in_valid = 0;
    chk("ready_low_busy", bad_ir, 0);
    chk("valid_held", {out_valid0, out_valid1}, 3);
    for (int e = 0; e < 4; e++) begin
      g = $signed(C0[e*64 +: 64]);
      chk($sformatf("c0_%0d", e), g, e0[e]);
      g = $signed(C1[e*8 +: 8]);
      chk($sformatf("c1_%0d", e), g, e1[e]);
    end
    chk("ovf0", ovf0, o0);
    chk("ovf1", ovf1, o1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("valid_drop", {out_valid0, out_valid1}, 0);
    chk("ready_back", {in_ready0, in_ready1}, 3);
  endtask
  initial begin
    int cnt;
    rst = 1; in_valid = 0; sel = 0; out_ready = 0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_c", (C0 != 0) || (C1 != 0), 0);
    chk("rst_valid", {out_valid0, out_valid1}, 0);
    chk("rst_ovf", {ovf0, ovf1}, 0);
    chk("rst_busy", {busy0, busy1}, 0);
    chk("rst_ready", {in_ready0, in_ready1}, 0);
    rst = 0;
    #1 chk("ready_after_rst", {in_ready0, in_ready1}, 3);
    aa0 = '{1, 2, 3, 4}; bb0 = '{5, 6, 7, 8}; aa1 = aa0; bb1 = bb0;
    job(0, 5);
    job(1, 0);
    aa0 = '{-1, 0, 0, -1}; bb0 = '{-3, 4, 5, -6}; aa1 = aa0; bb1 = bb0;
    job(0, 1);
    aa0 = '{127, 127, 127, 127}; bb0 = aa0; aa1 = aa0; bb1 = aa0;
    job(0, 0);
    aa0 = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000}; bb0 = aa0;
    aa1 = '{-128, -128, -128, -128}; bb1 = '{127, 127, 127, 127};
    job(0, 2);
    aa1 = '{127, 0, 0, 0}; bb1 = aa1; aa0 = aa1; bb0 = aa1;
    job(1, 0);
    // abandon a job three cycles after accept
    aa0 = '{1, 2, 3, 4}; bb0 = '{5, 6, 7, 8}; aa1 = aa0; bb1 = bb0;
    @(negedge clk);
    pack();
    sel = 0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_valid", {out_valid0, out_valid1}, 0);
    chk("mid_rst_c", (C0 != 0) || (C1 != 0), 0);
    chk("mid_rst_busy", {busy0, busy1}, 0);
    @(negedge clk);
    rst = 0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) cnt++;
    end
    chk("no_stale_valid", cnt, 0);
    job(0, 0);
    for (int t = 0; t < 12; t++) begin
      for (int e = 0; e < 4; e++) begin
        aa0[e] = $urandom;
        bb0[e] = $urandom;
        aa1[e] = $urandom_range(0, 255) - 128;
        bb1[e] = $urandom_range(0, 255) - 128;
      end
      job(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/strassen_seq2x2.md
Name: strassen_seq2x2

Overview:
- Parametrised, resource-shared successor to the combinational 2x2 Strassen stage.
- Computes C = A x B for signed 2x2 matrices.
- Issues the seven Strassen products (or four in partial mode) through a single pipelined multiplier and accumulates them into C.
- Has valid/ready handshakes on input and output, output saturation, and an overflow flag. It is the leaf tile for deeper Strassen recursion in the SNN accelerator datapath.

Parameters:
- DATAWIDTH, 32: width of each signed input element.
- OUTWIDTH, 2*DATAWIDTH: width of each signed output element. Legal range is 2 to 2*DATAWIDTH+4.
- MULT_LATENCY, 1: register stages in the shared multiplier. Legal range is 1 to 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands A, B and sel are valid.
- in_ready  out  1  block can accept operands.
- A  in  4*DATAWIDTH  signed; element (r,c) at [(2r+c)*DATAWIDTH +: DATAWIDTH].
- B  in  4*DATAWIDTH  signed; same packing as A.
- sel  in  1  0 = full product; 1 = partial product (C01 and C10 only).
- out_valid  out  1  C_out and ovf are valid.
- out_ready  in  1  consumer accepts the result.
- C_out  out  4*OUTWIDTH  signed; same packing as A, with OUTWIDTH per element.
- ovf  out  1  at least one element of C_out saturated.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, out_valid = 0, C_out = 0, ovf = 0.
  - Product counter, accumulators and multiplier pipeline valid bits cleared.
  - in_ready rises in the first cycle after rst deasserts.
- States and transitions: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready: register A, B and sel; clear the accumulators; go to ISSUE.
- ISSUE issues one product per cycle, k = 1..P. P = 7 when sel = 0, P = 4 when sel = 1.
  - Full order: M0..M6.
  - Partial order: M1, M2, M3, M4.
  - Operands of each product: T and S are widened to DATAWIDTH+1 bits with sign extension before add/sub.
    - M0 = (A00+A11)(B00+B11)
    - M1 = (A10+A11)B00
    - M2 = A00(B01-B11)
    - M3 = A11(B10-B00)
    - M4 = (A00+A01)B11
    - M5 = (A10-A00)(B00+B01)
    - M6 = (A01-A11)(B10+B11)
  - After the last issue, go to DRAIN.
- Multiplier: product width 2*DATAWIDTH+2. The product issued in cycle k emerges in cycle k+MULT_LATENCY, tagged with its index.
- Accumulate: each emerging product is added into the accumulators, which are 2*DATAWIDTH+4 bits each. Products are routed by index:
  - C00 += M0 + M3 - M4 + M6
  - C01 += M2 + M4
  - C10 += M1 + M3
  - C11 += M0 - M1 + M2 + M5
- DRAIN:
  - Wait until the last product has been accumulated.
  - Then register the saturated results into C_out, set ovf, assert out_valid, and go to DONE.
  - out_valid is first high in cycle P+MULT_LATENCY+1, counting the accept cycle as 0. That is 9 cycles for full mode and 6 for partial mode when MULT_LATENCY = 1.
- Saturation: each accumulator clamps to [-2^(OUTWIDTH-1), 2^(OUTWIDTH-1)-1]. ovf = OR of the per-element clamp events.
- Partial mode: C00 and C11 output exactly 0 and never contribute to ovf.
- DONE:
  - C_out, ovf and out_valid are held stable while out_ready = 0.
  - When out_ready = 1: drop out_valid at the next edge and return to IDLE. in_ready is high in the following cycle.
  - in_valid is ignored in every state except IDLE. There is no overlap between jobs.
- The sel input is sampled only at accept. Changes to sel while busy have no effect.
- Reset mid-operation: the job is abandoned and no out_valid is produced. In-flight multiplier results are discarded.
- Arithmetic is two's complement throughout. Internal accumulation never wraps; clamping occurs only at the output stage.

Test Plan:
- Full mode, MULT_LATENCY=1: A=[1 2;3 4], B=[5 6;7 8], sel=0 -> C_out=[19 22;43 50], ovf=0, out_valid high 9 cycles after accept, in_ready low throughout.
- Partial mode: same operands, sel=1 -> C_out=[0 22;43 0], ovf=0, out_valid high 6 cycles after accept.
- Signed values: A=[-1 0;0 -1], B=[-3 4;5 -6], sel=0 -> C_out=[3 -4;-5 6]. Repeat with MULT_LATENCY=3 -> same result, out_valid at cycle 11.
- Saturation, DATAWIDTH=8, OUTWIDTH=8:
  - A all 127, B all 127 -> every element = 127 and ovf=1.
  - A all -128, B all 127 -> every element = -128 and ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> C_out and ovf stable, in_ready=0, a pulse on in_valid is ignored. Raise out_ready -> out_valid drops next cycle and in_ready rises the cycle after.
- Reset mid-job: assert rst 3 cycles after accept -> outputs zero immediately and out_valid never rises. A new job [1 2;3 4]x[5 6;7 8] then completes correctly with no stale products.
